// File: rtl/mem_read_b.sv
// mem_read_b: read-address sequencer for the B-matrix bank memories.
// Replays every column tile of B once per A row tile and skews the
// per-bank read streams by one advancing cycle per bank so the systolic
// array B edge receives staggered operands.
module mem_read_b #(
  parameter int N2           = 4,
  parameter int MATRIXSIZE_W = 16,
  parameter int ADDR_W       = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    en,
  input  logic [MATRIXSIZE_W-1:0] M1dN1,
  input  logic [MATRIXSIZE_W-1:0] M2,
  input  logic [MATRIXSIZE_W-1:0] M3dN2,
  output logic [N2*ADDR_W-1:0]    rd_addr_B,
  output logic [N2-1:0]           rd_en_B,
  output logic [N2-1:0]           tile_last_B,
  output logic                    busy,
  output logic                    done
);

  // DRAIN lasts N2-1 advancing cycles; the counter ends at N2-2.
  localparam int CNT_W      = (N2 > 2) ? $clog2(N2) : 1;
  localparam int DRAIN_LAST = (N2 > 1) ? (N2 - 2) : 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [MATRIXSIZE_W-1:0] r_M1dN1;
  logic [MATRIXSIZE_W-1:0] r_M2;
  logic [MATRIXSIZE_W-1:0] r_M3dN2;
  logic [MATRIXSIZE_W-1:0] r_rowCnt;
  logic [MATRIXSIZE_W-1:0] r_kCnt;
  logic [MATRIXSIZE_W-1:0] r_iCnt;
  logic [ADDR_W-1:0]       r_base;
  logic                    r_allIssued;
  logic [CNT_W-1:0]        r_drainCnt;

  logic [N2-1:0]              r_skewValid;
  logic [N2-1:0][ADDR_W-1:0]  r_skewAddr;
  logic [N2-1:0]              r_skewLast;

  logic                    w_idle;
  logic                    w_zeroDim;
  logic [MATRIXSIZE_W-1:0] w_dimM1;
  logic [MATRIXSIZE_W-1:0] w_dimM2;
  logic [MATRIXSIZE_W-1:0] w_dimM3;
  logic [MATRIXSIZE_W-1:0] w_curRow;
  logic [MATRIXSIZE_W-1:0] w_curK;
  logic [MATRIXSIZE_W-1:0] w_curI;
  logic [ADDR_W-1:0]       w_curBase;
  logic [MATRIXSIZE_W-1:0] w_nextRow;
  logic [MATRIXSIZE_W-1:0] w_nextK;
  logic [MATRIXSIZE_W-1:0] w_nextI;
  logic [ADDR_W-1:0]       w_nextBase;
  logic                    w_tileEnd;
  logic                    w_kWrap;
  logic                    w_iLast;
  logic                    w_final;
  logic [ADDR_W-1:0]       w_issueAddr;
  logic                    w_issue;
  logic                    w_advance;

  // Current loop position and its successor; in IDLE the loop starts from zero with live dimensions.
  always_comb begin
    w_idle      = (r_state == S_IDLE);
    w_zeroDim   = (M1dN1 == '0) || (M2 == '0) || (M3dN2 == '0);
    w_dimM1     = w_idle ? M1dN1 : r_M1dN1;
    w_dimM2     = w_idle ? M2    : r_M2;
    w_dimM3     = w_idle ? M3dN2 : r_M3dN2;
    w_curRow    = w_idle ? '0 : r_rowCnt;
    w_curK      = w_idle ? '0 : r_kCnt;
    w_curI      = w_idle ? '0 : r_iCnt;
    w_curBase   = w_idle ? '0 : r_base;
    w_tileEnd   = (w_curRow == w_dimM2 - MATRIXSIZE_W'(1));
    w_kWrap     = (w_curK == w_dimM3 - MATRIXSIZE_W'(1));
    w_iLast     = (w_curI == w_dimM1 - MATRIXSIZE_W'(1));
    w_final     = w_tileEnd && w_kWrap && w_iLast;
    w_issueAddr = w_curBase + ADDR_W'(w_curRow);
    w_nextRow   = w_curRow + MATRIXSIZE_W'(1);
    w_nextK     = w_curK;
    w_nextI     = w_curI;
    w_nextBase  = w_curBase;
    if (w_tileEnd) begin
      w_nextRow = '0;
      if (w_kWrap) begin
        w_nextK    = '0;
        w_nextI    = w_curI + MATRIXSIZE_W'(1);
        w_nextBase = '0;
      end else begin
        w_nextK    = w_curK + MATRIXSIZE_W'(1);
        w_nextBase = w_curBase + ADDR_W'(w_dimM2);
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode, issue strobe, pipeline advance and status outputs.
  always_comb begin
    w_nextState = r_state;
    w_issue     = 1'b0;
    w_advance   = en;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_advance = 1'b1;
        if (start) begin
          if (w_zeroDim) begin
            w_nextState = S_DONE;
          end else begin
            w_nextState = S_RUN;
            w_issue     = 1'b1;
          end
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (en) begin
          if (r_allIssued) begin
            if (N2 == 1) begin
              w_nextState = S_DONE;
            end else begin
              w_nextState = S_DRAIN;
            end
          end else begin
            w_issue = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (en && (r_drainCnt == CNT_W'(DRAIN_LAST))) begin
          w_nextState = S_DONE;
        end
      end
      S_DONE: begin
        w_advance   = 1'b1;
        done        = 1'b1;
        w_nextState = S_IDLE;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Dimension latch, loop counters and drain counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_M1dN1     <= '0;
      r_M2        <= '0;
      r_M3dN2     <= '0;
      r_rowCnt    <= '0;
      r_kCnt      <= '0;
      r_iCnt      <= '0;
      r_base      <= '0;
      r_allIssued <= 1'b0;
      r_drainCnt  <= '0;
    end else begin
      if (w_idle && start) begin
        r_M1dN1 <= M1dN1;
        r_M2    <= M2;
        r_M3dN2 <= M3dN2;
      end
      if (w_issue) begin
        r_rowCnt    <= w_nextRow;
        r_kCnt      <= w_nextK;
        r_iCnt      <= w_nextI;
        r_base      <= w_nextBase;
        r_allIssued <= w_final;
      end
      if (r_state != S_DRAIN) begin
        r_drainCnt <= '0;
      end else if (en) begin
        r_drainCnt <= r_drainCnt + CNT_W'(1);
      end
    end
  end

  // Skew shift register: stage 0 takes the new bank-0 read, stage b copies stage b-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_skewValid <= '0;
      r_skewAddr  <= '0;
      r_skewLast  <= '0;
    end else if (w_advance) begin
      r_skewValid[0] <= w_issue;
      r_skewAddr[0]  <= w_issue ? w_issueAddr : '0;
      r_skewLast[0]  <= w_issue && w_tileEnd;
      for (int b = 1; b < N2; b++) begin
        r_skewValid[b] <= r_skewValid[b-1];
        r_skewAddr[b]  <= r_skewAddr[b-1];
        r_skewLast[b]  <= r_skewLast[b-1];
      end
    end
  end

  assign rd_addr_B   = r_skewAddr;
  assign rd_en_B     = r_skewValid & {N2{en}};
  assign tile_last_B = r_skewLast;

endmodule

// File: tb/tb_mem_read_b.sv
// tb_mem_read_b: self-checking bench for mem_read_b with a cycle-level
// reference model derived from the loop order and skew rules.
module tb_mem_read_b;

  localparam int N2 = 4;
  localparam int MW = 16;
  localparam int AW = 12;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           en;
  logic [MW-1:0]  M1dN1;
  logic [MW-1:0]  M2;
  logic [MW-1:0]  M3dN2;
  logic [N2*AW-1:0] rd_addr_B;
  logic [N2-1:0]  rd_en_B;
  logic [N2-1:0]  tile_last_B;
  logic           busy;
  logic           done;

  int nCompared   = 0;
  int nMismatched = 0;

  int Bmat    [0:7][0:15];
  int bankMem [0:N2-1][0:4095];
  bit memCheck = 1'b0;

  mem_read_b #(.N2(N2), .MATRIXSIZE_W(MW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .en         (en),
    .M1dN1      (M1dN1),
    .M2         (M2),
    .M3dN2      (M3dN2),
    .rd_addr_B  (rd_addr_B),
    .rd_en_B    (rd_en_B),
    .tile_last_B(tile_last_B),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Bank-0 read n walks i (outer), k, r (inner); address is k*M2 + r.
  function automatic int expAddr(input int n, input int m2, input int m3);
    return ((((n / m2) % m3) * m2) + (n % m2)) & ((1 << AW) - 1);
  endfunction

  // One full pass from start to the idle cycle after done, checked every cycle against the model.
  task automatic run_pass(input int m1, input int m2, input int m3, input int enMode,
                          input bit spurious, output int doneCycle);
    int T;
    int s;
    bit zero;
    bit fin;
    logic [N2*AW-1:0] eAddr;
    logic [N2-1:0] eEn;
    logic [N2-1:0] eLast;
    bit eDone;
    bit eBusy;
    T = m1 * m2 * m3;
    zero = (T == 0);
    s = 0;
    fin = 1'b0;
    doneCycle = -1;
    @(negedge clk);
    M1dN1 = MW'(m1);
    M2    = MW'(m2);
    M3dN2 = MW'(m3);
    start = 1'b1;
    en    = (enMode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    M1dN1 = MW'($urandom_range(0, 9));
    M2    = MW'($urandom_range(0, 9));
    M3dN2 = MW'($urandom_range(0, 9));
    for (int c = 1; c < 2000 && !fin; c++) begin
      case (enMode)
        0:       en = 1'b1;
        1:       en = !(c == 3 || c == 4);
        default: en = ($urandom_range(0, 3) != 0);
      endcase
      start = spurious && ($urandom_range(0, 3) == 0);
      #1;
      eAddr = '0;
      eEn   = '0;
      eLast = '0;
      if (zero) begin
        eDone = (c == 1);
        eBusy = 1'b0;
      end else begin
        eDone = (s == T + N2 - 1);
        eBusy = (s < T + N2 - 1);
        for (int b = 0; b < N2; b++) begin
          if (!eDone && (s - b) >= 0 && (s - b) < T) begin
            eEn[b] = en;
            eAddr[b*AW +: AW] = AW'(expAddr(s - b, m2, m3));
            eLast[b] = (((s - b) % m2) == m2 - 1);
          end
        end
      end
      nCompared++;
      if (busy !== eBusy) begin
        nMismatched++;
        $display("[TB] FAIL busy c=%0d: got %b expected %b", c, busy, eBusy);
      end
      nCompared++;
      if (done !== eDone) begin
        nMismatched++;
        $display("[TB] FAIL done c=%0d: got %b expected %b", c, done, eDone);
      end
      nCompared++;
      if (rd_en_B !== eEn) begin
        nMismatched++;
        $display("[TB] FAIL rd_en_B c=%0d: got %b expected %b", c, rd_en_B, eEn);
      end
      nCompared++;
      if (rd_addr_B !== eAddr) begin
        nMismatched++;
        $display("[TB] FAIL rd_addr_B c=%0d: got %h expected %h", c, rd_addr_B, eAddr);
      end
      nCompared++;
      if (tile_last_B !== eLast) begin
        nMismatched++;
        $display("[TB] FAIL tile_last_B c=%0d: got %b expected %b", c, tile_last_B, eLast);
      end
      if (memCheck) begin
        for (int b = 0; b < N2; b++) begin
          if (eEn[b]) begin
            int kk;
            int rr;
            int got;
            kk  = ((s - b) / m2) % m3;
            rr  = (s - b) % m2;
            got = bankMem[b][rd_addr_B[b*AW +: AW]];
            nCompared++;
            if (got !== Bmat[rr][kk*N2 + b]) begin
              nMismatched++;
              $display("[TB] FAIL bank%0d data c=%0d: got %0d expected %0d",
                       b, c, got, Bmat[rr][kk*N2 + b]);
            end
          end
        end
      end
      if (done === 1'b1 && doneCycle < 0) doneCycle = c;
      if (eDone) fin = 1'b1;
      else if (en) s++;
      @(negedge clk);
    end
    start = 1'b0;
    en    = 1'b1;
    #1;
    nCompared++;
    if (busy !== 1'b0 || done !== 1'b0 || rd_en_B !== '0) begin
      nMismatched++;
      $display("[TB] FAIL idle after pass: got busy=%b done=%b rd_en=%b expected 0/0/0",
               busy, done, rd_en_B);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    en = 1'b1;
    M1dN1 = '0;
    M2 = '0;
    M3dN2 = '0;
    repeat (3) @(negedge clk);
    #1;
    nCompared++;
    if (rd_addr_B !== '0 || rd_en_B !== '0 || tile_last_B !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset values: got addr=%h en=%b last=%b busy=%b done=%b expected all 0",
               rd_addr_B, rd_en_B, tile_last_B, busy, done);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int dc;
    $display("[TB] basic pass M1dN1=1 M2=3 M3dN2=2");
    run_pass(1, 3, 2, 0, 1'b0, dc);
    nCompared++;
    if (dc !== 10) begin
      nMismatched++;
      $display("[TB] FAIL basic done cycle: got %0d expected 10", dc);
    end
  endtask

  task automatic test_replay_data();
    int dc;
    $display("[TB] replay pass M1dN1=2 with bank data");
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 2 * N2; c++) begin
        Bmat[r][c] = int'($urandom_range(1, 1000));
        bankMem[c % N2][(c / N2) * 3 + r] = Bmat[r][c];
      end
    end
    memCheck = 1'b1;
    run_pass(2, 3, 2, 0, 1'b0, dc);
    memCheck = 1'b0;
    nCompared++;
    if (dc !== 16) begin
      nMismatched++;
      $display("[TB] FAIL replay done cycle: got %0d expected 16", dc);
    end
  endtask

  task automatic test_stall();
    int dc;
    $display("[TB] stall in cycles 3-4");
    run_pass(1, 3, 2, 1, 1'b0, dc);
    nCompared++;
    if (dc !== 12) begin
      nMismatched++;
      $display("[TB] FAIL stall done cycle: got %0d expected 12", dc);
    end
  endtask

  task automatic test_zero_dim();
    int dc;
    $display("[TB] zero dimension");
    run_pass(1, 0, 2, 0, 1'b0, dc);
    nCompared++;
    if (dc !== 1) begin
      nMismatched++;
      $display("[TB] FAIL zero done cycle: got %0d expected 1", dc);
    end
  endtask

  task automatic test_back_to_back();
    int dc;
    $display("[TB] spurious start during pass");
    run_pass(1, 3, 2, 0, 1'b1, dc);
    nCompared++;
    if (dc !== 10) begin
      nMismatched++;
      $display("[TB] FAIL back-to-back done cycle: got %0d expected 10", dc);
    end
  endtask

  task automatic test_reset_midpass();
    int dc;
    bit bad;
    $display("[TB] reset in cycle 4");
    @(negedge clk);
    M1dN1 = 16'd1;
    M2    = 16'd3;
    M3dN2 = 16'd2;
    start = 1'b1;
    en    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    nCompared++;
    if (rd_addr_B !== '0 || rd_en_B !== '0 || tile_last_B !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset midpass outputs: got addr=%h en=%b last=%b busy=%b done=%b expected all 0",
               rd_addr_B, rd_en_B, tile_last_B, busy, done);
    end
    rst = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #1;
      if (busy !== 1'b0 || done !== 1'b0 || rd_en_B !== '0) bad = 1'b1;
    end
    nCompared++;
    if (bad) begin
      nMismatched++;
      $display("[TB] FAIL quiet after reset: got activity=1 expected 0");
    end
    run_pass(1, 3, 2, 0, 1'b0, dc);
    nCompared++;
    if (dc !== 10) begin
      nMismatched++;
      $display("[TB] FAIL restart done cycle: got %0d expected 10", dc);
    end
  endtask

  task automatic test_random();
    int dc;
    for (int p = 0; p < 8; p++) begin
      int m1;
      int m2;
      int m3;
      m1 = int'($urandom_range(1, 3));
      m2 = int'($urandom_range(0, 5));
      m3 = int'($urandom_range(1, 3));
      $display("[TB] random pass %0d: M1dN1=%0d M2=%0d M3dN2=%0d", p, m1, m2, m3);
      run_pass(m1, m2, m3, 2, 1'b1, dc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_replay_data();
    test_stall();
    test_zero_dim();
    test_back_to_back();
    test_reset_midpass();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/mem_read_b.md
# mem_read_B

Read-address sequencer for the B-matrix bank memories. It consumes the banked layout produced by the B write stage: bank `b`, address `k*M2 + r` holds `B[r][k*N2+b]`. It replays every column tile of B once per A row tile, and skews the bank streams by one cycle per bank so the systolic array receives correctly staggered operands. It sits between the B bank memories and the systolic-array B edge, and is started by the top-level controller once B loading completes.

## Interface
- `N2`, 4, number of B banks (systolic array columns)
- `MATRIXSIZE_W`, 16, width of dimension inputs
- `ADDR_W`, 12, bank address width
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  one-cycle request to begin a read pass; sampled only in IDLE
- `en`  in  1  pipeline advance enable (downstream ready); low = stall
- `M1dN1`  in  MATRIXSIZE_W  number of A row tiles; B is replayed this many times
- `M2`  in  MATRIXSIZE_W  inner dimension (rows of B)
- `M3dN2`  in  MATRIXSIZE_W  number of B column tiles
- `rd_addr_B`  out  N2*ADDR_W  per-bank read address; bank `b` in bits `[b*ADDR_W +: ADDR_W]`
- `rd_en_B`  out  N2  per-bank read enable
- `tile_last_B`  out  N2  per-bank marker: current read is `r == M2-1` of a tile
- `busy`  out  1  pass in progress
- `done`  out  1  one-cycle pulse when a pass completes

## Operation
- Dimensions are latched on accepted `start`. Changes during a pass are ignored.
- States:
  - IDLE: `start` transitions to RUN; if any dimension is 0, it goes to DONE instead.
  - RUN: issues bank-0 reads. After the last read it goes to DRAIN.
  - DRAIN: lasts `N2-1` advancing cycles. It then goes to DONE. If `N2 == 1`, DRAIN is skipped.
  - DONE: one cycle, then IDLE.
- Loop order, outermost first: `i` in `0..M1dN1-1`, `k` in `0..M3dN2-1`, `r` in `0..M2-1`.
  - Bank-0 address is `base + r`. `base` starts at 0 and increments by `M2` at each tile end.
  - `base` resets to 0 when `k` wraps, i.e. when the next `i` starts.
  - Addresses come from counters and adders only; no multiplier. Addresses are truncated to `ADDR_W`.
- Total bank-0 reads: `T = M1dN1*M3dN2*M2`.
- Skew: a shift register of `{valid, addr, last}`, `N2` deep. Bank `b` sees bank 0's stream delayed by `b` advancing cycles.
- Stall:
  - Counters, state and skew registers advance only on edges where `en == 1`.
  - `rd_en_B[b]` is the skew-stage valid gated by `en`, combinationally.
  - `rd_addr_B` and `tile_last_B` hold their values during a stall.
- `start` while not IDLE is ignored. `start` in the same cycle as `done` is ignored.
- Reset clears state to IDLE and clears all counters and skew registers. This includes reset mid-pass; no partial `done` is generated.

## Timing
- Reset values: `rd_addr_B = 0`, `rd_en_B = 0`, `tile_last_B = 0`, `busy = 0`, `done = 0`.
- `start` is sampled at edge E0. With `en` held high:
  - `busy` is high in cycles 1 through `T+N2-1`.
  - Bank `b` read `n` (0-based) is presented in cycle `1+b+n`.
  - `done` is high in cycle `T+N2` only, with `busy` low in that cycle.
- Zero dimension: `done` in cycle 1, `busy` never high, no `rd_en_B`.
- Each cycle with `en` low during a pass delays all subsequent events by one cycle.
- `en` is ignored in IDLE and in DONE.
- Bank memories have one-cycle read latency. Data alignment to the array is the consumer's responsibility.

## Test plan
- `N2=4`, `M1dN1=1`, `M2=3`, `M3dN2=2`, start at E0, `en=1`:
  - Bank 0 addresses 0,1,2,3,4,5 in cycles 1–6.
  - Bank 3 addresses 0..5 in cycles 4–9.
  - `tile_last_B[0]` high in cycles 3 and 6.
  - `done` in cycle 10.
- Same dimensions with `M1dN1=2`:
  - Bank 0 sequence is 0..5, 0..5 in cycles 1–12.
  - `done` in cycle 16.
  - Write B via the write stage first, then check each bank read returns `B[r][k*4+b]`.
- Stall: same as the first scenario, with `en=0` in cycles 3–4:
  - `rd_en_B = 0` in cycles 3–4 and `rd_addr_B` holds.
  - Bank 0 address 2 is presented in cycle 5.
  - `done` in cycle 12.
- `M2=0`: `done` in cycle 1, no `rd_en_B`. A second `start` during a pass has no effect on the sequence.
- Reset at cycle 4 of the first scenario: all outputs are 0 from cycle 5, no `done`. A fresh `start` afterwards gives the full first-scenario sequence.
